display_scan_decoder: RTL
=========================

// Module: display_scan_decoder
//
// PURPOSE
// Receive-side counterpart of the 4-digit multiplexed 7-segment display driver.
// Samples the scanned segment/select lines and decodes each segment pattern back to a hex nibble.
// Publishes a complete 4-digit word once per scan frame.
// Used for on-chip loopback self-check and for reading display-driven peripherals through uio pins.
//
// PARAMETERS
// SYNC_STAGES     2      input synchronizer depth (0 = inputs already in clk domain)
// STABLE_CYCLES   4      cycles {sel,seg} must hold unchanged before a digit is sampled (>=1)
// TIMEOUT         65536  cycles without a sampled digit before stale asserts
// SEG_ACTIVE_LOW  0      1 = seg_in bits are active-low; inverted at input
// SEL_ACTIVE_LOW  0      1 = sel_in bits are active-low; inverted at input
//
// PORTS
// clk          in   1   system clock
// rst_n        in   1   synchronous reset, active-low
// seg_in       in   8   {dp,g,f,e,d,c,b,a}
// sel_in       in   4   digit select, one-hot, bit0 = digit 0
// digits_out   out  16  {d3,d2,d1,d0} hex nibbles of last complete frame
// dp_out       out  4   decimal point per digit of last frame
// err_mask     out  4   per-digit undecodable-pattern flag of last frame
// frame_valid  out  1   1-cycle pulse when digits_out/dp_out/err_mask update
// proto_err    out  1   1-cycle pulse on scan-order violation
// stale        out  1   high when no digit sampled for TIMEOUT cycles
//
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): all outputs 0, sync flops 0, stability count 0, FSM=HUNT.
// - Inputs pass SYNC_STAGES flops, then polarity normalization to active-high.
// - Stability: count increments while normalized {sel,seg} equal previous cycle; any change clears it.
//   - Sample when count reaches STABLE_CYCLES-1, exactly once per dwell; no resample until a change.
// - sel all-zero (blanking) or not one-hot: never sampled; stability count held at 0.
// - Decode seg[6:0]: 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9 77=A 7C=b 39=C 5E=d 79=E 71=F.
//   - Any other pattern: nibble 0, that digit's err bit = 1. dp = seg[7].
// - FSM:
//   - HUNT: wait for a sample with sel=0001; store d0, go CAP with expected index 1.
//   - CAP: a sample with sel = expected index stores the digit and increments index.
//     - After the index-3 store: next cycle load digits_out/dp_out/err_mask from the staging regs.
//       Pulse frame_valid and go HUNT.
//     - A sample with sel=0001 restarts the frame (store d0, index 1) and pulses proto_err.
//     - Any other index: discard partial frame, pulse proto_err, go HUNT.
// - Outputs hold between frames; partial frames never reach outputs.
// - Latency: a d3 pattern stable from cycle t gives frame_valid at t+SYNC_STAGES+STABLE_CYCLES.
// - Staleness:
//   - Saturating idle counter cleared by every sample.
//   - stale=1 when the counter reaches TIMEOUT.
//   - stale=0 in the same cycle frame_valid pulses.
// - Reset mid-frame: staging discarded, outputs zeroed, FSM=HUNT immediately.
//
// TESTING
// 1 Scan 1,2,3,4 (06,5B,4F,66), dwell 8 cycles each, sel 0001..1000
//   -> frame_valid once; digits_out=16'h4321; err_mask=0.
// 2 Dwell only STABLE_CYCLES-1 cycles per digit -> no frame_valid ever.
// 3 Digit 2 pattern 0x00, others valid -> frame_valid; err_mask=4'b0100; nibble2=0.
// 4 Order 0001,0010,1000 -> proto_err pulse on the 1000 sample.
//   Then a clean scan A,b,C,d -> digits_out=16'hDCBA.
// 5 SEG_ACTIVE_LOW=1 and SEL_ACTIVE_LOW=1, inverted stimulus of test 1 -> digits_out=16'h4321.
// 6 Hold all-zero sel for TIMEOUT cycles -> stale=1; clean frame -> stale=0 with frame_valid.
//   rst_n low mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/display_scan_if.sv
// Scanned 7-segment input lines and decoded frame outputs of display_scan_decoder.
// master drives the scan lines; slave is the decoder.
interface display_scan_if;
    logic [7:0]  seg_in;
    logic [3:0]  sel_in;
    logic [15:0] digits_out;
    logic [3:0]  dp_out;
    logic [3:0]  err_mask;
    logic        frame_valid;
    logic        proto_err;
    logic        stale;

    modport master (
        output seg_in,
        output sel_in,
        input  digits_out,
        input  dp_out,
        input  err_mask,
        input  frame_valid,
        input  proto_err,
        input  stale
    );

    modport slave (
        input  seg_in,
        input  sel_in,
        output digits_out,
        output dp_out,
        output err_mask,
        output frame_valid,
        output proto_err,
        output stale
    );
endinterface

// File: rtl/display_scan_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment scan: samples stable digits,
// decodes them to hex and publishes one complete frame per scan.
module display_scan_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT        = 65536,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    display_scan_if.slave bus
);
    typedef enum logic {HUNT, CAP} state_e;

    localparam int CW = $clog2(STABLE_CYCLES + 1) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [11:0] POL = {{4{SEL_ACTIVE_LOW}}, {8{SEG_ACTIVE_LOW}}};

    logic [11:0] raw_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign raw_s = {bus.sel_in, bus.seg_in};
        end else begin : g_sync
            logic [11:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= {bus.sel_in, bus.seg_in};
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign raw_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [11:0] cur;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic        onehot;

    assign cur    = raw_s ^ POL;
    assign sel    = cur[11:8];
    assign seg    = cur[7:0];
    assign onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);

    function automatic logic [4:0] dec7(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = 5'h00;
            7'h06:   r = 5'h01;
            7'h5B:   r = 5'h02;
            7'h4F:   r = 5'h03;
            7'h66:   r = 5'h04;
            7'h6D:   r = 5'h05;
            7'h7D:   r = 5'h06;
            7'h07:   r = 5'h07;
            7'h7F:   r = 5'h08;
            7'h6F:   r = 5'h09;
            7'h77:   r = 5'h0A;
            7'h7C:   r = 5'h0B;
            7'h39:   r = 5'h0C;
            7'h5E:   r = 5'h0D;
            7'h79:   r = 5'h0E;
            7'h71:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    state_e      state_q;
    logic [1:0]  exp_q;
    logic [11:0] prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] idle_q, idle_d;
    logic [15:0] stg_dig_q, digits_q;
    logic [3:0]  stg_dp_q, stg_err_q, dp_q, err_q;
    logic        fv_q, pe_q, stale_q;

    logic [1:0]  idx;
    logic [4:0]  dec;
    logic [3:0]  nib;
    logic        derr;
    logic        dp;
    logic        sample;

    // Blanking and multi-select patterns pin the dwell count at zero.
    always_comb begin
        cnt_d = '0;
        if (onehot && (cur == prev_q)) begin
            if (cnt_q == CW'(STABLE_CYCLES)) cnt_d = cnt_q;
            else                             cnt_d = cnt_q + CW'(1);
        end
    end

    assign sample = onehot && (cnt_d == CW'(STABLE_CYCLES - 1));

    always_comb begin
        idx = 2'd0;
        if (onehot) begin
            unique case (1'b1)
                sel[0]:  idx = 2'd0;
                sel[1]:  idx = 2'd1;
                sel[2]:  idx = 2'd2;
                sel[3]:  idx = 2'd3;
                default: idx = 2'd0;
            endcase
        end
    end

    assign dec  = dec7(seg[6:0]);
    assign nib  = dec[3:0];
    assign derr = dec[4];
    assign dp   = seg[7];

    always_comb begin
        idle_d = '0;
        if (!sample) begin
            if (idle_q == TW'(TIMEOUT)) idle_d = idle_q;
            else                        idle_d = idle_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            exp_q     <= 2'd0;
            prev_q    <= '0;
            cnt_q     <= '0;
            idle_q    <= '0;
            stg_dig_q <= '0;
            stg_dp_q  <= '0;
            stg_err_q <= '0;
            digits_q  <= '0;
            dp_q      <= '0;
            err_q     <= '0;
            fv_q      <= 1'b0;
            pe_q      <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            prev_q  <= cur;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            stale_q <= (idle_d == TW'(TIMEOUT));
            fv_q    <= 1'b0;
            pe_q    <= 1'b0;
            if (sample) begin
                unique case (state_q)
                    HUNT: begin
                        if (idx == 2'd0) begin
                            stg_dig_q[3:0] <= nib;
                            stg_dp_q[0]    <= dp;
                            stg_err_q[0]   <= derr;
                            exp_q          <= 2'd1;
                            state_q        <= CAP;
                        end
                    end
                    CAP: begin
                        if (idx == exp_q) begin
                            stg_dig_q[{exp_q, 2'b00} +: 4] <= nib;
                            stg_dp_q[exp_q]  <= dp;
                            stg_err_q[exp_q] <= derr;
                            if (exp_q == 2'd3) begin
                                // Last digit bypasses staging so the frame lands one edge earlier.
                                digits_q <= {nib, stg_dig_q[11:0]};
                                dp_q     <= {dp, stg_dp_q[2:0]};
                                err_q    <= {derr, stg_err_q[2:0]};
                                fv_q     <= 1'b1;
                                state_q  <= HUNT;
                            end else begin
                                exp_q <= exp_q + 2'd1;
                            end
                        end else if (idx == 2'd0) begin
                            stg_dig_q[3:0] <= nib;
                            stg_dp_q[0]    <= dp;
                            stg_err_q[0]   <= derr;
                            exp_q          <= 2'd1;
                            pe_q           <= 1'b1;
                        end else begin
                            pe_q    <= 1'b1;
                            state_q <= HUNT;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign bus.digits_out  = digits_q;
    assign bus.dp_out      = dp_q;
    assign bus.err_mask    = err_q;
    assign bus.frame_valid = fv_q;
    assign bus.proto_err   = pe_q;
    assign bus.stale       = stale_q;
endmodule
